// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with valid/ready handshake and 2-entry skid buffer.
// Define PIPE_STAGE_PERF_EN to build the saturating stall/flush performance counters.
module pipe_stage_buf #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              freeze,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef struct packed {
    logic              v;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_e;
  logic   acc, drn;

  assign in_e = '{v: 1'b1, ctrl: in_ctrl, data: in_data};

  // in_ready depends on registered state only, so stalls never form a combinational chain
  assign in_ready  = rst_n & ~skid_q.v & ~freeze & ~flush;
  assign out_valid = main_q.v & ~freeze;
  assign out_ctrl  = main_q.v ? main_q.ctrl : '0;
  assign out_data  = main_q.data;
  assign occupancy = {1'b0, main_q.v} + {1'b0, skid_q.v};

  assign acc = in_valid & in_ready;
  assign drn = out_valid & out_ready;

  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      main_d = '0;
      skid_d = '0;
    end else if (!freeze) begin
      if (skid_q.v) begin
        // in_ready is low whenever the skid is full, so no accept can collide here
        if (drn) begin
          main_d = skid_q;
          skid_d = '0;
        end
      end else if (main_q.v) begin
        if (drn)      main_d = acc ? in_e : '0;
        else if (acc) skid_d = in_e;
      end else if (acc) begin
        main_d = in_e;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W:0]   flush_sum;

  assign flush_sum = {1'b0, flush_cnt_q} + {{(CNT_W-1){1'b0}}, occupancy};

  // out_valid is already low under freeze, so the stall counter holds there naturally
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush)
      flush_cnt_d = flush_sum[CNT_W] ? '1 : flush_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: scoreboard on the output handshake plus
// cycle-exact checks of occupancy, in_ready, flush, freeze and counters.
module tb_pipe_stage_buf;
  localparam int CTRL_W = 8;
  localparam int DATA_W = 128;
  localparam int CNT_W  = 16;
`ifdef PIPE_STAGE_PERF_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic              clk, rst_n, flush, freeze;
  logic              in_valid, in_ready, out_valid, out_ready;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [DATA_W-1:0] in_data, out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } sb_t;
  sb_t sb[$];

  int vectors = 0;
  int miscompares = 0;

  pipe_stage_buf #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .freeze(freeze),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DATA_W-1:0] mk(input logic [CTRL_W-1:0] c);
    return {16{c}} ^ {4{32'hA5C3_0F1E}};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c);
    in_valid = v;
    in_ctrl  = c;
    in_data  = v ? mk(c) : '0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on accept, pop on drain, discard on flush/reset
  always @(negedge clk) begin
    sb_t e;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready && !flush) begin
        if (sb.size() == 0) chk("sb_underflow", 128'(sb.size()), 128'd1);
        else begin
          e = sb.pop_front();
          chk("sb_ctrl", 128'(out_ctrl), 128'(e.ctrl));
          chk("sb_data", 128'(out_data), 128'(e.data));
        end
      end
      if (flush) sb.delete();
      if (in_valid && in_ready) sb.push_back('{ctrl: in_ctrl, data: in_data});
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; freeze = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_occ", 128'(occupancy), 128'd0);
    chk("rst_out_ctrl", 128'(out_ctrl), 128'd0);
    chk("rst_out_data", 128'(out_data), 128'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 128'(in_ready), 128'd1);
    nxt();

    // stream 1..10 with out_ready=1: lag of one cycle, no bubbles
    out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      drive(1'b1, CTRL_W'(k));
      @(negedge clk);
      chk("str_in_ready", 128'(in_ready), 128'd1);
      chk("str_out_valid", 128'(out_valid), (k > 1) ? 128'd1 : 128'd0);
      if (k > 1) chk("str_out_ctrl", 128'(out_ctrl), 128'(k - 1));
      nxt();
    end
    drive(1'b0, '0);
    @(negedge clk);
    chk("str_last_ctrl", 128'(out_ctrl), 128'd10);
    nxt();
    @(negedge clk);
    chk("str_idle_valid", 128'(out_valid), 128'd0);
    chk("str_idle_occ", 128'(occupancy), 128'd0);
    chk("bubble_data", 128'(out_data), 128'd0);
    nxt();

    // skid: stall downstream while 1,2,3 arrive
    out_ready = 1'b0;
    drive(1'b1, 8'd1);
    @(negedge clk); chk("skid_occ0", 128'(occupancy), 128'd0); nxt();
    drive(1'b1, 8'd2);
    @(negedge clk); chk("skid_occ1", 128'(occupancy), 128'd1);
    chk("skid_rdy1", 128'(in_ready), 128'd1); nxt();
    drive(1'b1, 8'd3);
    @(negedge clk); chk("skid_occ2", 128'(occupancy), 128'd2);
    chk("skid_rdy0", 128'(in_ready), 128'd0); nxt();
    @(negedge clk); chk("skid_occ2b", 128'(occupancy), 128'd2);
    chk("skid_hold_ctrl", 128'(out_ctrl), 128'd1); nxt();
    out_ready = 1'b1;
    @(negedge clk); chk("skid_rel1", 128'(out_ctrl), 128'd1);
    chk("skid_rel_rdy", 128'(in_ready), 128'd0); nxt();
    @(negedge clk); chk("skid_rel2", 128'(out_ctrl), 128'd2);
    chk("skid_rel_occ", 128'(occupancy), 128'd1); nxt();
    drive(1'b0, '0);
    @(negedge clk); chk("skid_rel3", 128'(out_ctrl), 128'd3); nxt();
    @(negedge clk); chk("skid_empty", 128'(occupancy), 128'd0); nxt();

    // freeze with one entry held
    out_ready = 1'b0;
    drive(1'b1, 8'h55);
    @(negedge clk); nxt();
    freeze = 1'b1; out_ready = 1'b1;
    drive(1'b1, 8'h66);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("frz_out_valid", 128'(out_valid), 128'd0);
      chk("frz_in_ready", 128'(in_ready), 128'd0);
      chk("frz_occ", 128'(occupancy), 128'd1);
      chk("frz_data", 128'(out_data), 128'(mk(8'h55)));
      nxt();
    end
    freeze = 1'b0;
    drive(1'b0, '0);
    @(negedge clk);
    chk("frz_resume_v", 128'(out_valid), 128'd1);
    chk("frz_resume_c", 128'(out_ctrl), 128'h55);
    nxt();
    @(negedge clk); chk("frz_drained", 128'(occupancy), 128'd0); nxt();

    // fresh reset, then 5 stall cycles (last is the flush cycle) and flush at occupancy 2
    rst_n = 1'b0;
    nxt();
    rst_n = 1'b1;
    out_ready = 1'b0;
    drive(1'b1, 8'd1); nxt();
    drive(1'b1, 8'd2); nxt();
    drive(1'b0, '0);
    nxt(); nxt();
    @(negedge clk);
    chk("perf_stall3", 128'(stall_cnt), PERF ? 128'd3 : 128'd0);
    nxt();
    flush = 1'b1;
    drive(1'b1, 8'h77);
    @(negedge clk);
    chk("fl_in_ready", 128'(in_ready), 128'd0);
    chk("fl_occ_pre", 128'(occupancy), 128'd2);
    nxt();
    flush = 1'b0;
    drive(1'b0, '0);
    @(negedge clk);
    chk("fl_occ", 128'(occupancy), 128'd0);
    chk("fl_out_valid", 128'(out_valid), 128'd0);
    chk("fl_out_ctrl", 128'(out_ctrl), 128'd0);
    chk("fl_out_data", 128'(out_data), 128'd0);
    chk("perf_stall", 128'(stall_cnt), PERF ? 128'd5 : 128'd0);
    chk("perf_flush", 128'(flush_cnt), PERF ? 128'd2 : 128'd0);
    nxt();
    @(negedge clk);
    chk("fl_dropped", 128'(occupancy), 128'd0);
    chk("perf_stall_hold", 128'(stall_cnt), PERF ? 128'd5 : 128'd0);
    nxt();

    // asynchronous reset mid-stream at occupancy 2
    drive(1'b1, 8'hA1); nxt();
    drive(1'b1, 8'hA2); nxt();
    drive(1'b0, '0);
    chk("ar_occ_pre", 128'(occupancy), 128'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 128'(out_valid), 128'd0);
    chk("ar_out_ctrl", 128'(out_ctrl), 128'd0);
    chk("ar_occ", 128'(occupancy), 128'd0);
    chk("ar_in_ready", 128'(in_ready), 128'd0);
    chk("ar_out_data", 128'(out_data), 128'd0);
    chk("ar_stall_cnt", 128'(stall_cnt), 128'd0);
    chk("ar_flush_cnt", 128'(flush_cnt), 128'd0);
    nxt();
    rst_n = 1'b1;
    @(negedge clk);
    chk("ar_occ_post", 128'(occupancy), 128'd0);
    chk("sb_left", 128'(sb.size()), 128'd0);
    nxt();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
